// File: rtl/wasm_leb_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_pkg
//  Description : Shared types and constants for the LEB128 u32 reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package wasm_pkg;

    // Reader sequencing: wait for request, fetch bytes, present result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    // A u32 needs at most ceil(32/7) = 5 LEB bytes
    localparam int             LEB_MAX_BYTES    = 5;
    localparam int             LEB_CONT_BIT     = 7;
    localparam logic [6:0]     LEB_PAYLOAD_MASK = 7'h7F;

endpackage : wasm_pkg
`default_nettype wire

// File: rtl/wasm_leb_reader_accum.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_leb_accum
//  Description : Combinational step of the LEB128 decoder. Merges one ROM
//                byte into the running accumulator and decides whether the
//                field ends here and whether it is malformed.
//                Optional macro WASM_SLEB_EN adds signed (SLEB128) decoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module wasm_leb_accum
    import wasm_pkg::*;
#(
    parameter int MAX_BYTES = LEB_MAX_BYTES
) (
    input  logic [31:0] acc,
    input  logic [2:0]  count,
    input  logic [7:0]  data,
`ifdef WASM_SLEB_EN
    input  logic        is_signed,
`endif
    output logic [31:0] next_acc,
    output logic        finish,
    output logic        error
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic        w_cont;
    logic        w_last_slot;
    logic        w_ovf;

    // Payload lands at bit 7*count; anything pushed above bit 31 is overflow
    assign w_shamt     = {3'd0, count} * 6'd7;
    assign w_shifted   = {57'd0, data[6:0] & LEB_PAYLOAD_MASK} << w_shamt;
    assign w_cont      = data[LEB_CONT_BIT];
    assign w_last_slot = (int'(count) + 1) == MAX_BYTES;
    assign w_ovf       = |w_shifted[63:32];
    assign finish      = !w_cont || w_last_slot;

    // Value merge and error classification for this byte
    always_comb begin
        next_acc = acc | w_shifted[31:0];
        error    = w_cont && w_last_slot;
`ifdef WASM_SLEB_EN
        if (is_signed) begin
            if (count == 3'd4) begin
                // Bits [6:3] of the 5th byte are bit 31 plus its sign copies
                error = error || !((data[6:3] == 4'h0) || (data[6:3] == 4'hF));
            end else if (!w_cont && data[6]) begin
                next_acc = next_acc | (32'hFFFF_FFFF << (w_shamt + 6'd7));
            end
        end else begin
            error = error || w_ovf;
        end
`else
        error = error || w_ovf;
`endif
    end

endmodule : wasm_leb_accum
`default_nettype wire

// File: rtl/wasm_leb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_leb_reader
//  Description : Decodes one LEB128 u32 from byte-wide ROM starting at a
//                requested address; returns value, encoded length and the
//                address of the next unread byte.
//                Optional macro WASM_SLEB_EN adds the req_signed input.
//  Revision    : 1.0 - initial release
// ============================================================================
module wasm_leb_reader
    import wasm_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_BYTES = LEB_MAX_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
`ifdef WASM_SLEB_EN
    input  logic              req_signed,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    input  logic [7:0]        rom_data,
    input  logic              rom_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_value,
    output logic [2:0]        res_len,
    output logic [ADDR_W-1:0] res_next_addr,
    output logic              res_error
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t      r_state;
    logic [31:0] r_acc;
    logic [2:0]  r_count;
    logic [31:0] w_next_acc;
    logic        w_finish;
    logic        w_error;
`ifdef WASM_SLEB_EN
    logic        r_signed;
`endif

    assign req_ready = (r_state == IDLE);

    wasm_leb_accum #(
        .MAX_BYTES (MAX_BYTES)
    ) u_accum (
        .acc       (r_acc),
        .count     (r_count),
        .data      (rom_data),
`ifdef WASM_SLEB_EN
        .is_signed (r_signed),
`endif
        .next_acc  (w_next_acc),
        .finish    (w_finish),
        .error     (w_error)
    );

    // Request / fetch / result sequencing with registered ROM and result ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_acc         <= 32'd0;
            r_count       <= 3'd0;
            rom_addr      <= '0;
            rom_read_en   <= 1'b0;
            res_valid     <= 1'b0;
            res_value     <= 32'd0;
            res_len       <= 3'd0;
            res_next_addr <= '0;
            res_error     <= 1'b0;
`ifdef WASM_SLEB_EN
            r_signed      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        rom_addr    <= req_addr;
                        rom_read_en <= 1'b1;
                        r_count     <= 3'd0;
                        r_acc       <= 32'd0;
`ifdef WASM_SLEB_EN
                        r_signed    <= req_signed;
`endif
                        r_state     <= READ;
                    end
                end
                READ: begin
                    // Address advances on every consumed byte, so the ROM
                    // never sees the same address requested twice in a row
                    if (rom_ready) begin
                        rom_addr <= rom_addr + c_addr_one;
                        if (w_finish) begin
                            rom_read_en   <= 1'b0;
                            res_value     <= w_next_acc;
                            res_len       <= r_count + 3'd1;
                            res_next_addr <= rom_addr + c_addr_one;
                            res_error     <= w_error;
                            res_valid     <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_acc   <= w_next_acc;
                            r_count <= r_count + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : wasm_leb_reader
`default_nettype wire

// File: tb/tb_wasm_leb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wasm_leb_reader
//  Description : Self-checking bench for wasm_leb_reader: directed cases plus
//                randomized encodings checked against an arithmetic model.
//                Signed cases are built when WASM_SLEB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wasm_leb_reader;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_signed;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read_en;
    logic [7:0]        rom_data;
    logic              rom_ready;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_value;
    logic [2:0]        res_len;
    logic [ADDR_W-1:0] res_next_addr;
    logic              res_error;

    logic [7:0] mem [0:255];
    logic       stray;
    int         reads;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    wasm_leb_reader #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
`ifdef WASM_SLEB_EN
        .req_signed    (req_signed),
`endif
        .rom_addr      (rom_addr),
        .rom_read_en   (rom_read_en),
        .rom_data      (rom_data),
        .rom_ready     (rom_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_value     (res_value),
        .res_len       (res_len),
        .res_next_addr (res_next_addr),
        .res_error     (res_error)
    );

    // ROM: samples the address one edge, pulses rom_ready the next
    initial begin
        rom_ready = 1'b0;
        rom_data  = 8'h00;
        reads     = 0;
    end
    always @(posedge clk) begin
        if (rom_ready) begin
            rom_ready <= 1'b0;
        end else if (rom_read_en || stray) begin
            rom_ready <= 1'b1;
            rom_data  <= mem[rom_addr[7:0]];
            if (rom_read_en) reads <= reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: LEB128 decode by plain arithmetic on a 64-bit integer
    task automatic ref_decode(input logic [31:0] addr, input logic sgn,
                              output logic [31:0] val, output int len, output logic err);
        longint unsigned acc = 0;
        logic [7:0] b = 8'h00;
        int  n = 0;
        bit  more = 1'b1;
        err = 1'b0;
        while (more) begin
            b    = mem[8'(addr + 32'(n))];
            acc  = acc + (64'(b & 8'h7F) << (7 * n));
            n++;
            more = b[7];
            if (more && n == 5) begin
                err  = 1'b1;
                more = 1'b0;
            end
        end
        val = acc[31:0];
        if (sgn) begin
            if (n < 5 && !b[7] && b[6]) val = 32'(acc - (64'd1 << (7 * n)));
            if (n == 5 && !(acc < 64'h8000_0000 || acc >= 64'h7_8000_0000)) err = 1'b1;
        end else if (acc > 64'hFFFF_FFFF) begin
            err = 1'b1;
        end
        len = n;
    endtask

    // Issue one request and wait (bounded) for res_valid; lat = edges after accept
    task automatic run_req(input logic [31:0] addr, input logic sgn, output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_signed = sgn;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_req(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] v, input int n,
                              input logic [31:0] nxt, input logic e, input int lat);
        chk({tag, "_value"}, 64'(res_value), 64'(v));
        chk({tag, "_len"},   64'(res_len), 64'(n));
        chk({tag, "_next"},  64'(res_next_addr), 64'(nxt));
        chk({tag, "_err"},   64'(res_error), 64'(e));
        chk({tag, "_lat"},   64'(lat), 64'(2 * n));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, "_rom_rd"},   64'(rom_read_en), 64'd0);
        chk({tag, "_valid"},    64'(res_valid), 64'd0);
        chk({tag, "_value"},    64'(res_value), 64'd0);
        chk({tag, "_len"},      64'(res_len), 64'd0);
        chk({tag, "_next"},     64'(res_next_addr), 64'd0);
        chk({tag, "_err"},      64'(res_error), 64'd0);
        chk({tag, "_req_rdy"},  64'(req_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        int          base;
        int          elen;
        logic [31:0] eval;
        logic        eerr;
        logic [31:0] a;
        logic        sgn;
        int          n;
        bit          bad;
        logic [31:0] held_val;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_signed = 1'b0;
        res_ready = 1'b0; stray = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte
        mem[8'h10] = 8'h05;
        base = reads;
        run_req(32'h10, 1'b0, lat);
        expect_res("single", 32'd5, 1, 32'h11, 1'b0, lat);
        finish_req(0);
        chk("single_idle", 64'(req_ready), 64'd1);

        // Three bytes, exactly three ROM reads
        mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
        base = reads;
        run_req(32'h20, 1'b0, lat);
        expect_res("three", 32'h0009_8765, 3, 32'h23, 1'b0, lat);
        chk("three_reads", 64'(reads - base), 64'd3);
        finish_req(0);

        // Max u32 and overflow on the 5th byte
        for (int i = 0; i < 4; i++) begin
            mem[8'h50 + 8'(i)] = 8'hFF;
            mem[8'h60 + 8'(i)] = 8'hFF;
        end
        mem[8'h54] = 8'h0F; mem[8'h64] = 8'h1F;
        run_req(32'h50, 1'b0, lat);
        expect_res("maxu32", 32'hFFFF_FFFF, 5, 32'h55, 1'b0, lat);
        finish_req(0);
        run_req(32'h60, 1'b0, lat);
        expect_res("ovf", 32'hFFFF_FFFF, 5, 32'h65, 1'b1, lat);
        finish_req(0);

        // Overlong: stops after 5 bytes, never reads 0x45
        for (int i = 0; i < 5; i++) mem[8'h40 + 8'(i)] = 8'h80;
        mem[8'h45] = 8'h00;
        base = reads;
        run_req(32'h40, 1'b0, lat);
        expect_res("overlong", 32'd0, 5, 32'h45, 1'b1, lat);
        chk("overlong_reads", 64'(reads - base), 64'd5);
        finish_req(0);

        // Address wraps at the top of the space
        mem[8'hFE] = 8'h81; mem[8'hFF] = 8'h80; mem[8'h00] = 8'h01;
        run_req(32'hFFFF_FFFE, 1'b0, lat);
        expect_res("wrap", 32'h0000_4001, 3, 32'h1, 1'b0, lat);
        finish_req(0);

        // Backpressure with a stray ROM pulse while results are held
        run_req(32'h20, 1'b0, lat);
        held_val = res_value;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stray = (i == 3);
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || rom_read_en !== 1'b0 ||
                res_value !== held_val || res_len !== 3'd3 || res_next_addr !== 32'h23 ||
                res_error !== 1'b0) bad = 1'b1;
        end
        stray = 1'b0;
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_value", 64'(held_val), 64'h0009_8765);
        finish_req(0);
        chk("bp_idle", 64'(req_ready), 64'd1);
        chk("bp_valid_low", 64'(res_valid), 64'd0);
        chk("bp_keep", 64'(res_value), 64'h0009_8765);

        // Reset after the first byte of a 3-byte decode, with a response in flight
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h20; req_signed = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ignored", 64'({req_ready, rom_read_en, res_valid}), 64'b100);
        run_req(32'h10, 1'b0, lat);
        expect_res("after_rst", 32'd5, 1, 32'h11, 1'b0, lat);
        finish_req(0);

`ifdef WASM_SLEB_EN
        mem[8'h70] = 8'h7F;
        run_req(32'h70, 1'b1, lat);
        expect_res("s_m1", 32'hFFFF_FFFF, 1, 32'h71, 1'b0, lat);
        finish_req(0);
        mem[8'h80] = 8'hC0; mem[8'h81] = 8'hBB; mem[8'h82] = 8'h78;
        run_req(32'h80, 1'b1, lat);
        expect_res("s_neg", 32'hFFFE_1DC0, 3, 32'h83, 1'b0, lat);
        finish_req(0);
        run_req(32'h70, 1'b0, lat);
        expect_res("u_7f", 32'h0000_007F, 1, 32'h71, 1'b0, lat);
        finish_req(0);
`endif

        // Randomized encodings against the arithmetic model
        for (int t = 0; t < 30; t++) begin
            a = $urandom;
            n = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) begin
                if (i < n - 1)       mem[8'(a + 32'(i))] = 8'($urandom) | 8'h80;
                else if (i == n - 1) mem[8'(a + 32'(i))] = 8'($urandom) & 8'h7F;
                else                 mem[8'(a + 32'(i))] = 8'($urandom);
            end
`ifdef WASM_SLEB_EN
            sgn = 1'($urandom);
`else
            sgn = 1'b0;
`endif
            run_req(a, sgn, lat);
            ref_decode(a, req_signed, eval, elen, eerr);
            expect_res($sformatf("rnd%0d", t), eval, elen, a + 32'(elen), eerr, lat);
            finish_req($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_wasm_leb_reader
`default_nettype wire
